// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and loads IF/ID.
// Optional IF_PERF_EN adds fetched/squashed event counters.
module if_stage #(
  parameter int unsigned PC_W             = 8,
  parameter int unsigned INST_W           = 32,
  parameter int unsigned REDIRECT_BUBBLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [INST_W-1:0] if_id_inst,
  output logic [PC_W-1:0]   if_id_pc,
  output logic              if_id_valid,
`ifdef IF_PERF_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_squashed,
`endif
  output logic              flush_id
);

  typedef enum logic [1:0] {RUN, HOLD, SQUASH} state_t;

  localparam logic [2:0] BUBBLES = 3'(REDIRECT_BUBBLES);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [PC_W-1:0]   ipc_q, ipc_d;
  logic              valid_q, valid_d;
  logic              fetch, bubble;

`ifdef IF_PERF_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] squashed_q, squashed_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      pc_q       <= '0;
      inst_q     <= '0;
      ipc_q      <= '0;
      valid_q    <= 1'b0;
`ifdef IF_PERF_EN
      fetched_q  <= '0;
      squashed_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      ipc_q      <= ipc_d;
      valid_q    <= valid_d;
`ifdef IF_PERF_EN
      fetched_q  <= fetched_d;
      squashed_q <= squashed_d;
`endif
    end
  end

  // Redirect overrides everything, including a squash already in progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (redirect_valid) begin
      if (BUBBLES == 3'd0) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        state_d = SQUASH;
        cnt_d   = BUBBLES;
      end
    end else begin
      unique case (state_q)
        RUN:  if (stall)  state_d = HOLD;
        HOLD: if (!stall) state_d = RUN;
        SQUASH: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    bubble  = redirect_valid || (state_q == SQUASH);
    fetch   = !bubble && !stall;
    pc_d    = pc_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    if (bubble) begin
      inst_d  = '0;
      ipc_d   = '0;
      valid_d = 1'b0;
      if (redirect_valid) pc_d = redirect_pc;
    end else if (fetch) begin
      inst_d  = imem_rdata;
      ipc_d   = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + PC_W'(1);
    end
`ifdef IF_PERF_EN
    fetched_d  = fetched_q + (fetch ? 32'd1 : 32'd0);
    squashed_d = squashed_q + (bubble ? 32'd1 : 32'd0);
`endif
  end

  assign imem_addr   = pc_q;
  assign if_id_inst  = inst_q;
  assign if_id_pc    = ipc_q;
  assign if_id_valid = valid_q;
  assign flush_id    = redirect_valid;
`ifdef IF_PERF_EN
  assign perf_fetched  = fetched_q;
  assign perf_squashed = squashed_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomized self-checking bench for if_stage: two instances (1 and 3 redirect bubbles)
// share stimulus and are compared against a queue-free behavioural fetch model.
module tb_if_stage;

  localparam int NI = 2;
  localparam int RBS [NI] = '{1, 3};

  logic clk, reset, stall, redirect_valid;
  logic [7:0] redirect_pc;
  logic [NI-1:0][7:0]  addr, ipc;
  logic [NI-1:0][31:0] rdata, inst;
  logic [NI-1:0]       valid, flush;
  logic [31:0] mem [256];
`ifdef IF_PERF_EN
  logic [NI-1:0][31:0] pf, ps;
`endif

  int n_checks = 0;
  int n_errors = 0;

  int          m_pc    [NI];
  int          m_left  [NI];
  logic [31:0] m_inst  [NI];
  int          m_ipc   [NI];
  logic        m_valid [NI];
  int unsigned m_fetch [NI];
  int unsigned m_sq    [NI];

  if_stage u_dut1 (
    .clk(clk), .reset(reset), .imem_addr(addr[0]), .imem_rdata(rdata[0]),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_inst(inst[0]), .if_id_pc(ipc[0]), .if_id_valid(valid[0]),
`ifdef IF_PERF_EN
    .perf_fetched(pf[0]), .perf_squashed(ps[0]),
`endif
    .flush_id(flush[0])
  );

  if_stage #(.REDIRECT_BUBBLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .imem_addr(addr[1]), .imem_rdata(rdata[1]),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_inst(inst[1]), .if_id_pc(ipc[1]), .if_id_valid(valid[1]),
`ifdef IF_PERF_EN
    .perf_fetched(pf[1]), .perf_squashed(ps[1]),
`endif
    .flush_id(flush[1])
  );

  assign rdata[0] = mem[addr[0]];
  assign rdata[1] = mem[addr[1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_pc[i] = 0; m_left[i] = 0; m_inst[i] = '0; m_ipc[i] = 0;
      m_valid[i] = 1'b0; m_fetch[i] = 0; m_sq[i] = 0;
    end
  endtask

  // One rising edge of the fetch stage, from its architectural rules.
  task automatic model_edge(input logic s, input logic rv, input logic [7:0] rpc);
    for (int i = 0; i < NI; i++) begin
      if (rv) begin
        m_pc[i] = int'(rpc);
        m_inst[i] = '0; m_ipc[i] = 0; m_valid[i] = 1'b0;
        m_left[i] = RBS[i];
        m_sq[i]++;
      end else if (m_left[i] > 0) begin
        m_inst[i] = '0; m_ipc[i] = 0; m_valid[i] = 1'b0;
        m_left[i]--;
        m_sq[i]++;
      end else if (!s) begin
        m_inst[i] = mem[m_pc[i]];
        m_ipc[i] = m_pc[i];
        m_valid[i] = 1'b1;
        m_pc[i] = (m_pc[i] + 1) % 256;
        m_fetch[i]++;
      end
    end
  endtask

  task automatic check_state();
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("u%0d.imem_addr", RBS[i]), 64'(addr[i]), 64'(m_pc[i]));
      check_eq($sformatf("u%0d.if_id_inst", RBS[i]), 64'(inst[i]), 64'(m_inst[i]));
      check_eq($sformatf("u%0d.if_id_pc", RBS[i]), 64'(ipc[i]), 64'(m_ipc[i]));
      check_eq($sformatf("u%0d.if_id_valid", RBS[i]), 64'(valid[i]), 64'(m_valid[i]));
`ifdef IF_PERF_EN
      check_eq($sformatf("u%0d.perf_fetched", RBS[i]), 64'(pf[i]), 64'(m_fetch[i]));
      check_eq($sformatf("u%0d.perf_squashed", RBS[i]), 64'(ps[i]), 64'(m_sq[i]));
`endif
    end
  endtask

  // Inputs change after the falling edge; outputs are sampled at the next falling edge.
  task automatic step(input logic s, input logic rv, input logic [7:0] rpc);
    stall = s; redirect_valid = rv; redirect_pc = rpc;
    #1;
    for (int i = 0; i < NI; i++)
      check_eq($sformatf("u%0d.flush_id", RBS[i]), 64'(flush[i]), 64'(rv));
    @(posedge clk);
    model_edge(s, rv, rpc);
    @(negedge clk);
    check_state();
  endtask

  // Reset raised between edges must clear outputs before any clock edge.
  task automatic do_reset();
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("u%0d.async_addr", RBS[i]), 64'(addr[i]), 64'd0);
      check_eq($sformatf("u%0d.async_valid", RBS[i]), 64'(valid[i]), 64'd0);
      check_eq($sformatf("u%0d.async_inst", RBS[i]), 64'(inst[i]), 64'd0);
      check_eq($sformatf("u%0d.async_pc", RBS[i]), 64'(ipc[i]), 64'd0);
    end
    @(posedge clk);
    @(negedge clk);
    check_state();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    for (int a = 0; a < 256; a++) mem[a] = $urandom;
    mem[0] = 32'h0000_1001;
    mem[1] = 32'h0000_2002;
    mem[2] = 32'h0000_3003;
    mem[3] = 32'h0000_4004;
    mem[7] = 32'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_state();
    reset = 1'b0;

    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 8'h00);
    do_reset();
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h0A);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 8'h00);

    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h20);
    step(1'b1, 1'b1, 8'h30);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h00);

    step(1'b0, 1'b1, 8'hFF);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h05);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 8'h00);

    step(1'b0, 1'b1, 8'h40);
    do_reset();
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    for (int k = 0; k < 600; k++) begin
      logic s, rv;
      logic [7:0] rpc;
      s   = ($urandom_range(3) == 0);
      rv  = ($urandom_range(9) == 0);
      rpc = ($urandom_range(7) == 0) ? 8'hFE : 8'($urandom);
      step(s, rv, rpc);
      if (k == 300) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined CPU, sitting directly upstream of decode. It owns the program counter, drives the word-addressed instruction memory, and loads the IF/ID pipeline register. It honours decode-side stalls and EX-side control-flow redirects (J, JM, BRZ, BRN taken), inserting NOP bubbles while a redirect settles.

## Interface
Parameters:
- PC_W, 8, PC and instruction-memory address width (word addresses)
- INST_W, 32, instruction width
- REDIRECT_BUBBLES, 1, extra bubble cycles after a redirect (0..7)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- imem_addr  out  PC_W  instruction-memory read address; always equals the PC
- imem_rdata  in  INST_W  instruction at imem_addr, combinational same-cycle read
- stall  in  1  hold PC and IF/ID (load-use hazard from decode)
- redirect_valid  in  1  EX resolved a taken jump or branch this cycle
- redirect_pc  in  PC_W  target word address, valid with redirect_valid
- if_id_inst  out  INST_W  registered instruction; 0 (NOP) when a bubble
- if_id_pc  out  PC_W  registered address of if_id_inst (used by SVPC)
- if_id_valid  out  1  if_id_inst is a real fetched instruction
- flush_id  out  1  combinational; high while redirect_valid is high, tells decode to squash ID/EX

## Operation
- FSM states: RUN, HOLD, SQUASH.
- RUN, no stall or redirect: IF/ID <= {imem_rdata, pc, valid=1}; pc <= pc+1.
- RUN, stall=1, no redirect: go to HOLD. pc and IF/ID are unchanged.
- HOLD: stays while stall=1. When stall=0, it acts as RUN that cycle and returns to RUN.
- Any state, redirect_valid=1:
  - Redirect has priority over stall and over any in-progress squash.
  - pc <= redirect_pc; IF/ID <= {0, 0, valid=0}.
  - If REDIRECT_BUBBLES=0, next state is RUN. Otherwise next state is SQUASH with the bubble counter loaded with REDIRECT_BUBBLES.
- SQUASH:
  - Each cycle IF/ID <= bubble, pc holds, and the counter decrements.
  - At counter=1, the state goes to RUN.
  - stall is ignored in SQUASH.
- PC arithmetic is modulo 2^PC_W: pc = 2^PC_W-1 increments to 0.
- A fetched all-zero word is a NOP but is still marked valid=1.

## Timing
- Reset values: pc=0, imem_addr=0, if_id_inst=0, if_id_pc=0, if_id_valid=0, state=RUN, counter=0. flush_id follows redirect_valid.
- Fetch latency: an instruction at address A appears on if_id_inst one rising edge after pc=A, provided there is no stall or redirect.
- Redirect: taken at the edge where redirect_valid=1.
  - The first target instruction appears on IF/ID REDIRECT_BUBBLES+1 edges later.
  - Bubbles are emitted during the intervening cycles.
- Reset asserted mid-operation: all registers clear asynchronously, with no wait for clk. The first fetch of address 0 happens on the first edge after reset deasserts.

## Configuration
- IF_PERF_EN defined:
  - Adds output perf_fetched (32 bits), which increments on every edge that loads a valid instruction into IF/ID.
  - Adds output perf_squashed (32 bits), which increments on every edge that loads a bubble because of a redirect or SQUASH.
  - Both counters reset to 0 and wrap at 2^32.
- IF_PERF_EN undefined: both ports and their counters are absent. All other behaviour is identical.

## Test plan
- Sequential fetch: mem[0..3] = ADD, SUB, NEG, INC encodings; release reset.
  - Edges 1..4 give if_id_pc = 0,1,2,3 with matching if_id_inst and if_id_valid=1.
  - imem_addr = 4 after edge 4.
- Stall: stall=1 for 2 cycles while pc=2.
  - if_id_pc stays 1 and imem_addr stays 2 for those cycles.
  - After release, if_id_pc=2 and then 3.
- Redirect with REDIRECT_BUBBLES=1: pulse redirect_valid with redirect_pc=0x0A while pc=5.
  - flush_id=1 in the same cycle.
  - Next 2 edges give bubbles (if_id_valid=0, if_id_inst=0).
  - Third edge gives if_id_pc=0x0A.
- Redirect during stall and during SQUASH: redirect to 0x20 while stall=1, then redirect to 0x30 one cycle later.
  - Final fetch starts at 0x30.
  - Exactly 1 bubble is counted after the second redirect.
- Wrap and async reset: PC_W=8, redirect to 0xFF.
  - Following fetches use addresses 0xFF then 0x00.
  - Asserting reset between edges clears if_id_valid and imem_addr to 0 immediately.
- IF_PERF_EN: run the redirect scenario; perf_fetched and perf_squashed match the counts of valid and bubble loads (e.g. 6 and 2).
